reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//   Parametrised successor of the 4x16 datapath register file: WIDTH-bit data,
//   2**ADDR_W registers, two async read ports, one sync write port.
//   Adds async active-low reset and a hardware clear sweeper (busy/stall).
//   Adds optional same-cycle write->read forwarding.
//   Sits between the decode stage (read) and the writeback stage (write).
// PARAMETERS
//   WIDTH     16  data width of every register and port
//   ADDR_W    2   register address width; NREGS = 2**ADDR_W (localparam)
//   ZERO_REG  1   1: register 0 is hardwired to 0 (writes ignored); 0: normal register
// PORTS
//   clock     in   1        single clock; all state updates on its rising edge
//   reset_n   in   1        asynchronous, active-low reset
//   rr1       in   ADDR_W   read address, port 1
//   rr2       in   ADDR_W   read address, port 2
//   rd1       out  WIDTH    read data, port 1 (combinational from rr1)
//   rd2       out  WIDTH    read data, port 2 (combinational from rr2)
//   wr        in   ADDR_W   write address
//   wd        in   WIDTH    write data
//   regwrite  in   1        write request, sampled at posedge clock
//   clr_req   in   1        start a clear sweep (level; sampled in IDLE only)
//   busy      out  1        registered; 1 while the sweep is in progress
//   wr_drop   out  1        registered 1-cycle pulse: a write request was discarded
// BEHAVIOUR
//   Reset (reset_n=0, async):
//     - all registers = 0; state = IDLE; sweep index = 0; busy = 0; wr_drop = 0.
//     - rd1/rd2 therefore read 0.
//     - Reset mid-sweep aborts the sweep immediately; no pending state survives.
//   Read: rdN = reg[rrN], zero latency.
//     - Reads of r0 return 0 when ZERO_REG=1.
//     - Reads during a sweep return current (possibly partly cleared) contents.
//   Write: accepted when regwrite=1, state=IDLE and clr_req=0.
//     - Accepted write: reg[wr] <= wd at the edge; visible on rdN the next cycle.
//     - wr=0 with ZERO_REG=1: silently ignored; not a drop.
//     - regwrite=1 while busy=1, or in the same cycle clr_req starts a sweep:
//       write is discarded and wr_drop=1 for the following cycle.
//   Clear FSM, states IDLE and SWEEP:
//     - IDLE, clr_req=1 -> SWEEP; idx <= 0; busy <= 1.
//     - SWEEP: each cycle reg[idx] <= 0, idx <= idx+1.
//       On idx = NREGS-1: clear it, go to IDLE, busy <= 0.
//     - Sweep takes exactly NREGS cycles; busy is high for NREGS cycles.
//     - clr_req while in SWEEP is ignored; no restart, no queuing.
//     - clr_req held high at sweep end starts a new sweep on the next IDLE edge.
//     - idx wraps naturally at ADDR_W bits; no out-of-range access.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - if a write is accepted this cycle and rrN == wr (and wr != 0 when
//       ZERO_REG=1), rdN = wd combinationally (write-through forwarding).
//     - Dropped writes and ignored r0 writes are never forwarded.
//   Not defined: rdN always shows the pre-edge register contents; no forwarding.
// TESTING
//   1 Reset, then read all addresses -> rd1=rd2=16'h0000, busy=0, wr_drop=0.
//   2 Write r1=16'hA5A5 and r3=16'h1234, then rr1=1, rr2=3
//     -> rd1=A5A5, rd2=1234; write r0=16'hFFFF -> rd of r0 stays 0, wr_drop=0.
//   3 Load r1..r3 with 1,2,3; pulse clr_req -> busy=1 for exactly 4 cycles;
//     r1..r3 read 0 afterwards; regwrite r2=7 during busy -> wr_drop=1
//     next cycle, r2 stays 0.
//   4 Assert reset_n=0 in sweep cycle 2 -> busy=0 immediately, all regs 0;
//     write r2=9 after release -> r2=9.
//   5 BYPASS_EN: regwrite wr=2, wd=16'hBEEF, rr1=2 in the same cycle
//     -> rd1=BEEF before the edge.
//     Without the macro: rd1 = old r2 until after the edge.
//   6 Params WIDTH=32, ADDR_W=3: sweep lasts 8 cycles; write r7=32'hDEADBEEF
//     -> reads back DEADBEEF.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// and a hardware clear sweeper. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_param #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] rr1_i,
  input  logic [ADDR_W-1:0] rr2_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o,
  input  logic [ADDR_W-1:0] wr_i,
  input  logic [WIDTH-1:0]  wd_i,
  input  logic              regwrite_i,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              wr_drop_o
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];

  logic wr_accept;
  logic wr_en;
  logic sweeping;

  // A write only lands in IDLE when no sweep is starting; r0 writes are swallowed quietly.
  assign wr_accept = regwrite_i && (state_q == IDLE) && !clr_req_i;
  assign wr_en     = wr_accept && !((ZERO_REG != 0) && (wr_i == '0));
  assign wr_drop_d = regwrite_i && !wr_accept;
  assign sweeping  = (state_q == SWEEP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = SWEEP;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign regs_d[gi] = '0;
      end else begin : g_norm
        assign regs_d[gi] = (sweeping && (idx_q == ADDR_W'(gi))) ? '0 :
                            (wr_en && (wr_i == ADDR_W'(gi)))     ? wd_i :
                                                                   regs_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd1_o = regs_q[rr1_i];
    rd2_o = regs_q[rr2_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rr1_i == wr_i)) rd1_o = wd_i;
    if (wr_en && (rr2_i == wr_i)) rd2_o = wd_i;
`endif
  end

  assign busy_o    = busy_q;
  assign wr_drop_o = wr_drop_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed steps plus random traffic against an array model,
// and a second 32-bit / 8-register instance for the wide configuration.
module tb_reg_file_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  rr1, rr2, wr;
  logic [15:0] wd, rd1, rd2;
  logic        regwrite, clr, busy, drop;

  logic [2:0]  rr1b, rr2b, wrb;
  logic [31:0] wdb, rd1b, rd2b;
  logic        regwriteb, clrb, busyb, dropb;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl [4];
  int          cnt;
  logic        drop_m;

  reg_file_param dut (
    .clk_i(clk), .rst_n_i(rst_n), .rr1_i(rr1), .rr2_i(rr2), .rd1_o(rd1), .rd2_o(rd2),
    .wr_i(wr), .wd_i(wd), .regwrite_i(regwrite), .clr_req_i(clr),
    .busy_o(busy), .wr_drop_o(drop)
  );

  reg_file_param #(.WIDTH(32), .ADDR_W(3), .ZERO_REG(1)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .rr1_i(rr1b), .rr2_i(rr2b), .rd1_o(rd1b), .rd2_o(rd2b),
    .wr_i(wrb), .wd_i(wdb), .regwrite_i(regwriteb), .clr_req_i(clrb),
    .busy_o(busyb), .wr_drop_o(dropb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    cnt    = 0;
    drop_m = 1'b0;
  endtask

  // What the decode stage should see right now, given stored contents and the pending write.
  function automatic logic [15:0] mread(input logic [1:0] a);
    logic [15:0] v;
    v = mdl[a];
`ifdef REGFILE_BYPASS_EN
    if (regwrite && (cnt == 0) && !clr && (a == wr) && (wr != 2'd0)) v = wd;
`endif
    return v;
  endfunction

  task automatic model_edge();
    bit idle, acc;
    idle   = (cnt == 0);
    acc    = regwrite && idle && !clr;
    drop_m = regwrite && !acc;
    if (!idle) begin
      mdl[4 - cnt] = '0;
      cnt--;
    end else if (clr) begin
      cnt = 4;
    end else if (acc && (wr != 2'd0)) begin
      mdl[wr] = wd;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("rd1", {16'h0, rd1}, {16'h0, mread(rr1)});
    chk("rd2", {16'h0, rd2}, {16'h0, mread(rr2)});
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {31'h0, busy}, {31'h0, (cnt != 0)});
    chk("wr_drop", {31'h0, drop}, {31'h0, drop_m});
    @(negedge clk);
  endtask

  task automatic drive(input logic rw, input logic [1:0] a, input logic [15:0] d, input logic c);
    regwrite = rw;
    wr       = a;
    wd       = d;
    clr      = c;
  endtask

  int nb;

  initial begin
    rst_n = 1'b0;
    rr1 = '0; rr2 = '0; wr = '0; wd = '0; regwrite = 1'b0; clr = 1'b0;
    rr1b = '0; rr2b = '0; wrb = '0; wdb = '0; regwriteb = 1'b0; clrb = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rr1 = 2'(a); rr2 = 2'(3 - a);
      #1;
      chk("rst_rd1", {16'h0, rd1}, 32'h0);
      chk("rst_rd2", {16'h0, rd2}, 32'h0);
    end
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_drop", {31'h0, drop}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic writes and r0 behaviour
    drive(1'b1, 2'd1, 16'hA5A5, 1'b0); step();
    drive(1'b1, 2'd3, 16'h1234, 1'b0); step();
    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    rr1 = 2'd1; rr2 = 2'd3;
    #1;
    chk("t2_rd1", {16'h0, rd1}, 32'h0000A5A5);
    chk("t2_rd2", {16'h0, rd2}, 32'h00001234);
    drive(1'b1, 2'd0, 16'hFFFF, 1'b0); step();
    chk("t2_r0_drop", {31'h0, drop}, 32'h0);
    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    rr1 = 2'd0;
    #1;
    chk("t2_r0", {16'h0, rd1}, 32'h0);
    @(negedge clk);

    // Clear sweep with a write attempted while busy
    for (int a = 1; a < 4; a++) begin
      drive(1'b1, 2'(a), 16'(a), 1'b0); step();
    end
    drive(1'b0, 2'd0, 16'h0, 1'b1); step();
    chk("t3_busy_start", {31'h0, busy}, 32'h1);
    nb = 1;
    for (int i = 0; i < 6; i++) begin
      drive((i == 1), 2'd2, 16'd7, 1'b0);
      step();
      if (i == 1) chk("t3_drop", {31'h0, drop}, 32'h1);
      if (busy) nb++;
    end
    chk("t3_busy_cycles", nb, 4);
    for (int a = 1; a < 4; a++) begin
      rr1 = 2'(a);
      #1;
      chk("t3_cleared", {16'h0, rd1}, 32'h0);
    end
    @(negedge clk);

    // Reset in the middle of a sweep
    for (int a = 1; a < 4; a++) begin
      drive(1'b1, 2'(a), 16'(11 * a), 1'b0); step();
    end
    drive(1'b0, 2'd0, 16'h0, 1'b1); step();
    drive(1'b0, 2'd0, 16'h0, 1'b0); step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t4_busy", {31'h0, busy}, 32'h0);
    rr1 = 2'd1; rr2 = 2'd2;
    #1;
    chk("t4_r1", {16'h0, rd1}, 32'h0);
    chk("t4_r2", {16'h0, rd2}, 32'h0);
    rr1 = 2'd3;
    #1;
    chk("t4_r3", {16'h0, rd1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 16'd9, 1'b0); step();
    drive(1'b0, 2'd0, 16'h0, 1'b0);
    rr1 = 2'd2;
    #1;
    chk("t4_r2_after", {16'h0, rd1}, 32'd9);
    @(negedge clk);

    // Same-cycle write and read of the same register
    drive(1'b1, 2'd2, 16'hBEEF, 1'b0);
    rr1 = 2'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t5_fwd", {16'h0, rd1}, 32'h0000BEEF);
`else
    chk("t5_nofwd", {16'h0, rd1}, 32'd9);
`endif
    step();
    drive(1'b0, 2'd0, 16'h0, 1'b0);
    #1;
    chk("t5_after", {16'h0, rd1}, 32'h0000BEEF);
    @(negedge clk);

    // Random traffic against the model
    repeat (300) begin
      drive(1'($urandom % 2), 2'($urandom % 4), 16'($urandom), ($urandom % 16) == 0);
      rr1 = 2'($urandom % 4);
      rr2 = 2'($urandom % 4);
      step();
    end
    drive(1'b0, 2'd0, 16'h0, 1'b0);
    repeat (5) step();

    // Wide configuration
    wrb = 3'd7; wdb = 32'hDEADBEEF; regwriteb = 1'b1;
    @(negedge clk);
    regwriteb = 1'b0; rr1b = 3'd7;
    #1;
    chk("t6_r7", rd1b, 32'hDEADBEEF);
    clrb = 1'b1;
    @(negedge clk);
    clrb = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busyb) nb++;
      @(negedge clk);
    end
    chk("t6_busy_cycles", nb, 8);
    #1;
    chk("t6_r7_cleared", rd1b, 32'h0);
    chk("t6_drop", {31'h0, dropb}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
